// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with valid/ready input and output
// handshakes. Each frame carries FRAME_LEN data bits followed by two zero tail
// bits, so the shift register always ends the frame back in state 0.
module conv_encoder #(
  parameter int unsigned FRAME_LEN = 8,
  parameter logic [2:0]  G0        = 3'b111,
  parameter logic [2:0]  G1        = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] enc_pair,
  output logic       enc_valid,
  input  logic       enc_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CntW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {StIdle, StData, StTail, StDrain} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sr_q, sr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tail_q, tail_d;  // first tail bit already encoded
  logic [1:0]      pair_q, pair_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic            slot_free;
  logic            encode;
  logic            bit_in;
  logic [2:0]      win;

  // Next-state, encode decision and output-slot update.
  always_comb begin
    slot_free = !valid_q || enc_ready;
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    tail_d    = tail_q;
    done_d    = 1'b0;
    din_ready = 1'b0;
    encode    = 1'b0;
    bit_in    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StData;
      end
      StData: begin
        din_ready = slot_free;
        if (din_valid && slot_free) begin
          encode = 1'b1;
          bit_in = din;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CntW'(FRAME_LEN - 1)) state_d = StTail;
        end
      end
      StTail: begin
        // Tail bits are zeros generated internally; din_valid plays no part.
        if (slot_free) begin
          encode = 1'b1;
          tail_d = 1'b1;
          if (tail_q) begin
            tail_d  = 1'b0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (valid_q && enc_ready) begin
          done_d  = 1'b1;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    win = {bit_in, sr_q[0], sr_q[1]};
    if (encode) sr_d = {sr_q[0], bit_in};

    // A new pair overwrites the slot even while the old one drains: no bubble.
    pair_d  = pair_q;
    valid_d = valid_q;
    if (encode) begin
      pair_d  = {^(win & G0), ^(win & G1)};
      valid_d = 1'b1;
    end else if (valid_q && enc_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; synchronous reset drops any in-flight pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      tail_q  <= 1'b0;
      pair_q  <= 2'b00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      pair_q  <= pair_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign enc_pair   = pair_q;
  assign enc_valid  = valid_q;
  assign frame_done = done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder datapath. It accepts a fixed-length frame of data bits over a valid/ready handshake and emits one 2-bit code symbol per input bit. It then appends two zero tail bits so the trellis terminates in state 0. Output pairs use the same bit ordering the decoder's branch-metric units expect on their received-pair input.

## Interface
- FRAME_LEN, 8: data bits per frame; legal range is 1 or greater.
- G0, 3'b111: generator polynomial for code bit [1] (octal 7).
- G1, 3'b101: generator polynomial for code bit [0] (octal 5).
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a frame; honoured only in IDLE.
- din  input  1  data bit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  encoder accepts din this cycle.
- enc_pair  output  2  code symbol; [1] is the G0 parity, [0] is the G1 parity.
- enc_valid  output  1  enc_pair is valid.
- enc_ready  input  1  downstream accepts enc_pair this cycle.
- busy  output  1  high whenever the state is not IDLE.
- frame_done  output  1  one-cycle pulse when the frame's final tail pair is accepted downstream.

## Operation
- State register sr[1:0]: sr[0] holds the previous bit, sr[1] the bit before it. The window is w = {b, sr[0], sr[1]}, where b is the current bit.
- Code bits: enc_pair[1] = ^(w & G0), enc_pair[0] = ^(w & G1). After each encoded bit, sr <= {sr[0], b}.
- FSM states: IDLE, DATA, TAIL, DRAIN.
  - IDLE: sr = 0, bit counter = 0. start = 1 moves to DATA.
  - DATA: din_ready = !enc_valid || enc_ready. A transfer occurs when din_valid && din_ready; it encodes din and increments the counter. The transfer that makes counter = FRAME_LEN moves to TAIL.
  - TAIL: din_ready = 0. Internally encodes b = 0 whenever (!enc_valid || enc_ready), with no dependence on din_valid. Exactly 2 tail bits are encoded; after the second, move to DRAIN.
  - DRAIN: wait until enc_valid && enc_ready. In that cycle, pulse frame_done, clear sr and the counter, and return to IDLE.
- Output register:
  - On an encode event, load enc_pair and set enc_valid = 1.
  - Otherwise, if enc_valid && enc_ready, clear enc_valid.
  - While enc_valid = 1 and enc_ready = 0, enc_pair holds stable.
- Each frame produces exactly FRAME_LEN + 2 pairs.
- The counter is $clog2(FRAME_LEN+1) bits wide and never wraps within a frame.
- start outside IDLE is ignored. din_valid outside DATA is ignored and never consumed.

## Timing
- Reset values: enc_pair = 2'b00, enc_valid = 0, din_ready = 0, busy = 0, frame_done = 0, sr = 0, counter = 0, state IDLE.
- Reset mid-frame aborts the frame immediately. The in-flight pair is dropped (enc_valid = 0 on the next cycle) and no frame_done is issued.
- Latency: a bit accepted at edge n appears on enc_pair / enc_valid after edge n.
- Throughput: 1 pair/cycle with enc_ready held high.
- Simultaneous accept and drain (enc_valid && enc_ready && new encode): the new pair replaces the old one and enc_valid stays 1, with no bubble.
- start is sampled in IDLE; din_ready first rises the cycle after start.
- The first tail bit is encoded in the cycle after the last data transfer, provided the output slot is free.
- frame_done is asserted in the same cycle as the final handshake's edge result; busy falls in that same cycle.
- Back-to-back frames: start may be asserted in the cycle after frame_done.
- Minimum frame duration is FRAME_LEN + 4 cycles: 1 start cycle, FRAME_LEN + 2 pair cycles, 1 drain cycle.

## Test plan
- FRAME_LEN = 8, din = 1,0,1,1,0,0,0,0, enc_ready = 1 -> enc_pair sequence 11,10,00,01,01,11,00,00, then tail pairs 00,00. frame_done pulses once after the 10th pair.
- FRAME_LEN = 4, din = 1,1,1,1 -> pairs 11,01,10,10, then tail 01,11. The final sr is 0; confirm via a following frame with din = 0000 producing all 00 pairs.
- Backpressure: same stimulus as the first test with enc_ready toggling randomly. Required: identical pair sequence, enc_pair stable while stalled, din_ready low whenever enc_valid && !enc_ready, and no lost or duplicated bits.
- din_valid gaps: a data bit every third cycle. Required: identical output sequence, and enc_valid low during gaps once drained.
- Reset after the 3rd data bit of a frame. Required: next cycle enc_valid = 0, busy = 0, frame_done never pulses. A new frame then encodes from sr = 0 (first bit 1 -> 11).
- start pulsed during DATA and during TAIL -> no effect. start in the cycle after frame_done -> new frame begins, with din_ready high the following cycle.
